// File: rtl/snn_buf_pkg.sv
// Shared sizing helpers and mode encodings for the SNN spike-event buffers.
package snn_buf_pkg;

  localparam int FWFT_OFF = 0;  // registered read, one cycle latency
  localparam int FWFT_ON  = 1;  // head entry visible on dout without a pop

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: advances on inc, wraps DEPTH-1 -> 0, clr returns to 0.
// One register stage; with DEPTH=1 the wrap value is 0 so the pointer stays 0.
module fifo_wrap_ptr
  import snn_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// Arbitrary-depth ready/valid FIFO with registered status, sticky error flags and flush.
// Read latency 1 cycle (FWFT=0) or 0 (FWFT=1); din_ready drops when full unless a pop frees a slot.
module stream_fifo
  import snn_buf_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int FWFT          = FWFT_OFF,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic                          read_en,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          dout_valid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int LW = level_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [LW-1:0]         level_nxt;
  logic                  rd_acc;
  logic                  wr_acc;

  // clear suppresses both transfers so nothing is counted or flagged that cycle
  assign rd_acc    = read_en && !empty && !clear;
  assign wr_acc    = din_valid && (!full || rd_acc) && !clear;
  assign din_ready = !full || read_en;

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (rd_acc),
    .clr     (clear),
    .ptr     (rd_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (wr_acc),
    .clr     (clear),
    .ptr     (wr_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_comb begin
    level_nxt = level;
    if (clear) begin
      level_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      level_nxt = level + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_nxt = level - LW'(1);
    end
  end

  // Status flags are derived from the next level so they line up with level itself
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= (AFULL_THRESH == 0);
      almost_empty <= 1'b1;
    end else begin
      level        <= level_nxt;
      empty        <= (level_nxt == '0);
      full         <= (level_nxt == LW'(DEPTH));
      almost_full  <= (int'(level_nxt) >= AFULL_THRESH);
      almost_empty <= (int'(level_nxt) <= AEMPTY_THRESH);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (din_valid && !wr_acc && !clear) || (overflow && !clr_err);
      underflow <= (read_en && empty && !clear) || (underflow && !clr_err);
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign dout       = empty ? '0 : mem[rd_ptr];
      assign dout_valid = !empty;
    end else begin : g_reg_read
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end else begin
          dout_valid <= rd_acc;
          if (rd_acc) begin
            dout <= mem[rd_ptr];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: DEPTH=5 registered-read instance plus DEPTH=4 FWFT instance.
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       a_clear, a_din_valid, a_read_en, a_clr_err;
  logic [7:0] a_din, a_dout;
  logic       a_din_ready, a_dout_valid, a_empty, a_full, a_almost_full, a_almost_empty;
  logic       a_overflow, a_underflow;
  logic [2:0] a_level;

  logic       b_clear, b_din_valid, b_read_en, b_clr_err;
  logic [7:0] b_din, b_dout;
  logic       b_din_ready, b_dout_valid, b_empty, b_full, b_almost_full, b_almost_empty;
  logic       b_overflow, b_underflow;
  logic [2:0] b_level;

  int         checks = 0;
  int         errors = 0;
  int         mlev   = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(a_clear), .din(a_din), .din_valid(a_din_valid),
    .din_ready(a_din_ready), .read_en(a_read_en), .dout(a_dout), .dout_valid(a_dout_valid),
    .empty(a_empty), .full(a_full), .almost_full(a_almost_full), .almost_empty(a_almost_empty),
    .level(a_level), .overflow(a_overflow), .underflow(a_underflow), .clr_err(a_clr_err)
  );

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(b_clear), .din(b_din), .din_valid(b_din_valid),
    .din_ready(b_din_ready), .read_en(b_read_en), .dout(b_dout), .dout_valid(b_dout_valid),
    .empty(b_empty), .full(b_full), .almost_full(b_almost_full), .almost_empty(b_almost_empty),
    .level(b_level), .overflow(b_overflow), .underflow(b_underflow), .clr_err(b_clr_err)
  );

  // One cycle on instance A; the scoreboard tracks accepted writes and the expected read word
  task automatic drive_a(input logic wr, input logic [7:0] d, input logic rd);
    logic ra, wa;
    ra = rd && (mlev > 0);
    wa = wr && ((mlev < 5) || ra);
    a_din_valid = wr;
    a_din       = d;
    a_read_en   = rd;
    @(posedge clk);
    #1;
    a_din_valid = 1'b0;
    a_read_en   = 1'b0;
    if (ra) exp_d = sb_q.pop_front();
    if (wa) sb_q.push_back(d);
    mlev = mlev + (wa ? 1 : 0) - (ra ? 1 : 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {a_clear, a_din_valid, a_read_en, a_clr_err, a_din} = '0;
    {b_clear, b_din_valid, b_read_en, b_clr_err, b_din} = '0;
    #12;
    checks++;
    if ({a_empty, a_full, a_din_ready, a_almost_empty, a_almost_full} !== 5'b10110) begin
      errors++;
      $display("FAIL reset_status: e/f/rdy/ae/af=%b expected 10110",
               {a_empty, a_full, a_din_ready, a_almost_empty, a_almost_full});
    end
    checks++;
    if (a_level !== 3'd0 || a_dout !== 8'h00 || a_dout_valid !== 1'b0 ||
        a_overflow !== 1'b0 || a_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: level=%0d dout=%h vld=%b ovf=%b unf=%b expected 0 00 0 0 0",
               a_level, a_dout, a_dout_valid, a_overflow, a_underflow);
    end
    checks++;
    if (b_dout !== 8'h00 || b_dout_valid !== 1'b0 || b_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_fwft: dout=%h vld=%b empty=%b expected 00 0 1", b_dout, b_dout_valid, b_empty);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 5; i++) drive_a(1'b1, 8'(8'h11 * i), 1'b0);
    checks++;
    if (a_full !== 1'b1 || a_level !== 3'd5 || a_din_ready !== 1'b0 || a_almost_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: full=%b level=%0d rdy=%b af=%b expected 1 5 0 1",
               a_full, a_level, a_din_ready, a_almost_full);
    end
    for (int i = 1; i <= 5; i++) begin
      drive_a(1'b0, 8'h00, 1'b1);
      checks++;
      if (a_dout_valid !== 1'b1 || a_dout !== exp_d || exp_d !== 8'(8'h11 * i)) begin
        errors++;
        $display("FAIL drain_%0d: dout=%h vld=%b expected %h vld=1", i, a_dout, a_dout_valid, 8'(8'h11 * i));
      end
    end
    drive_a(1'b0, 8'h00, 1'b0);
    checks++;
    if (a_dout_valid !== 1'b0 || a_dout !== 8'h55 || a_empty !== 1'b1 || a_level !== 3'd0) begin
      errors++;
      $display("FAIL drain_end: vld=%b dout=%h empty=%b level=%0d expected 0 55 1 0",
               a_dout_valid, a_dout, a_empty, a_level);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= 5; i++) drive_a(1'b1, 8'(8'h11 * i), 1'b0);
    a_read_en = 1'b1;
    #1;
    checks++;
    if (a_din_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_rw_ready: din_ready=%b expected 1", a_din_ready);
    end
    drive_a(1'b1, 8'hAA, 1'b1);
    checks++;
    if (a_dout !== 8'h11 || a_dout_valid !== 1'b1 || a_level !== 3'd5 || a_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_rw: dout=%h vld=%b level=%0d ovf=%b expected 11 1 5 0",
               a_dout, a_dout_valid, a_level, a_overflow);
    end
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 8'h00, 1'b1);
      checks++;
      if (a_dout_valid !== 1'b1 || a_dout !== exp_d) begin
        errors++;
        $display("FAIL full_rw_pop%0d: dout=%h vld=%b expected %h", i, a_dout, a_dout_valid, exp_d);
      end
    end
    checks++;
    if (a_dout !== 8'hAA || a_empty !== 1'b1) begin
      errors++;
      $display("FAIL full_rw_last: dout=%h empty=%b expected AA 1", a_dout, a_empty);
    end
  endtask

  task automatic test_wrap();
    int max_lev = 0;
    drive_a(1'b1, 8'd0, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      drive_a(i < 13, 8'(i), 1'b1);
      if (int'(a_level) > max_lev) max_lev = int'(a_level);
      checks++;
      if (a_dout_valid !== 1'b1 || a_dout !== exp_d || exp_d !== 8'(i - 1)) begin
        errors++;
        $display("FAIL wrap_%0d: dout=%h vld=%b expected %h", i, a_dout, a_dout_valid, 8'(i - 1));
      end
    end
    checks++;
    if (max_lev > 2 || a_empty !== 1'b1 || a_underflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_level: max=%0d empty=%b unf=%b expected <=2 1 0", max_lev, a_empty, a_underflow);
    end
  endtask

  task automatic test_fwft();
    b_din = 8'h07;
    b_din_valid = 1'b1;
    @(posedge clk);
    #1;
    b_din_valid = 1'b0;
    checks++;
    if (b_dout !== 8'h07 || b_dout_valid !== 1'b1 || b_level !== 3'd1) begin
      errors++;
      $display("FAIL fwft_show: dout=%h vld=%b level=%0d expected 07 1 1", b_dout, b_dout_valid, b_level);
    end
    b_read_en = 1'b1;
    @(posedge clk);
    #1;
    b_read_en = 1'b0;
    checks++;
    if (b_dout !== 8'h00 || b_dout_valid !== 1'b0 || b_empty !== 1'b1) begin
      errors++;
      $display("FAIL fwft_pop: dout=%h vld=%b empty=%b expected 00 0 1", b_dout, b_dout_valid, b_empty);
    end
    for (int i = 0; i < 2; i++) begin
      b_din = 8'(8'hC0 + i);
      b_din_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    b_din_valid = 1'b0;
    b_read_en = 1'b1;
    @(posedge clk);
    #1;
    b_read_en = 1'b0;
    checks++;
    if (b_dout !== 8'hC1 || b_dout_valid !== 1'b1 || b_level !== 3'd1) begin
      errors++;
      $display("FAIL fwft_second: dout=%h vld=%b level=%0d expected C1 1 1", b_dout, b_dout_valid, b_level);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 5; i++) drive_a(1'b1, 8'(8'hE0 + i), 1'b0);
    drive_a(1'b1, 8'hEE, 1'b0);
    checks++;
    if (a_overflow !== 1'b1 || a_level !== 3'd5 || a_underflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow: ovf=%b level=%0d unf=%b expected 1 5 0", a_overflow, a_level, a_underflow);
    end
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 8'h00, 1'b1);
      checks++;
      if (a_dout !== exp_d || exp_d !== 8'(8'hE0 + i)) begin
        errors++;
        $display("FAIL ovf_drain%0d: dout=%h expected %h", i, a_dout, 8'(8'hE0 + i));
      end
    end
    drive_a(1'b0, 8'h00, 1'b1);
    checks++;
    if (a_underflow !== 1'b1 || a_overflow !== 1'b1 || a_dout_valid !== 1'b0 || a_level !== 3'd0) begin
      errors++;
      $display("FAIL underflow: unf=%b ovf=%b vld=%b level=%0d expected 1 1 0 0",
               a_underflow, a_overflow, a_dout_valid, a_level);
    end
    a_clr_err = 1'b1;
    drive_a(1'b0, 8'h00, 1'b1);
    checks++;
    if (a_underflow !== 1'b1 || a_overflow !== 1'b0) begin
      errors++;
      $display("FAIL set_wins: unf=%b ovf=%b expected 1 0", a_underflow, a_overflow);
    end
    drive_a(1'b0, 8'h00, 1'b0);
    a_clr_err = 1'b0;
    checks++;
    if (a_underflow !== 1'b0 || a_overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: unf=%b ovf=%b expected 0 0", a_underflow, a_overflow);
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) drive_a(1'b1, 8'(8'h31 + i), 1'b0);
    checks++;
    if (a_level !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre: level=%0d expected 3", a_level);
    end
    a_clear = 1'b1;
    a_din_valid = 1'b1;
    a_din = 8'h99;
    a_read_en = 1'b1;
    @(posedge clk);
    #1;
    {a_clear, a_din_valid, a_read_en} = '0;
    sb_q.delete();
    mlev = 0;
    checks++;
    if (a_level !== 3'd0 || a_empty !== 1'b1 || a_dout_valid !== 1'b0 ||
        a_overflow !== 1'b0 || a_underflow !== 1'b0) begin
      errors++;
      $display("FAIL flush: level=%0d empty=%b vld=%b ovf=%b unf=%b expected 0 1 0 0 0",
               a_level, a_empty, a_dout_valid, a_overflow, a_underflow);
    end
    drive_a(1'b1, 8'h41, 1'b0);
    drive_a(1'b1, 8'h42, 1'b0);
    a_din_valid = 1'b1;
    a_din = 8'h43;
    a_read_en = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (a_dout !== 8'h41 || a_dout_valid !== 1'b1 || a_level !== 3'd2) begin
      errors++;
      $display("FAIL burst: dout=%h vld=%b level=%0d expected 41 1 2", a_dout, a_dout_valid, a_level);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (a_level !== 3'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_dout !== 8'h00 ||
        a_dout_valid !== 1'b0 || a_almost_empty !== 1'b1 || a_almost_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: level=%0d empty=%b full=%b dout=%h vld=%b ae=%b af=%b expected 0 1 0 00 0 1 0",
               a_level, a_empty, a_full, a_dout, a_dout_valid, a_almost_empty, a_almost_full);
    end
    {a_din_valid, a_read_en} = '0;
    #1;
    checks++;
    if (a_din_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_ready: din_ready=%b expected 1", a_din_ready);
    end
    reset_n = 1'b1;
    sb_q.delete();
    mlev = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_wrap();
    test_fwft();
    test_errors();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
